// File: rtl/router_pkt_src.sv
// Packet source for a 1x3 router input port: buffers a host payload, then sends
// header / payload / parity under router busy flow control and samples err.
module router_pkt_src #(
    parameter int unsigned ERR_WAIT = 3,
    parameter int unsigned MAX_LEN  = 63
) (
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       start_i,
    input  logic [1:0] dest_addr_i,
    input  logic [5:0] pay_len_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic       busy_i,
    input  logic       err_i,
    output logic       pkt_valid_o,
    output logic [7:0] data_out_o,
    output logic       tx_active_o,
    output logic       done_o,
    output logic       err_flag_o
);

    localparam int unsigned LEN_W  = 6;
    localparam int unsigned WAIT_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_ERRW
    } state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wcnt_q;
    logic [LEN_W-1:0]  rcnt_q;
    logic [1:0]        addr_q;
    logic [7:0]        parity_q;
    logic [WAIT_W-1:0] wait_q;
    logic              s_ready_q;
    logic              pkt_valid_q;
    logic [7:0]        data_out_q;
    logic              tx_active_q;
    logic              done_q;
    logic              err_flag_q;
    logic [7:0]        buf_q [MAX_LEN];

    logic [7:0]       hdr;
    logic [LEN_W-1:0] last_idx;
    logic             load_wr;

    assign hdr      = {len_q, addr_q};
    assign last_idx = LEN_W'(len_q - 1'b1);
    assign load_wr  = (state_q == S_LOAD) && s_valid_i && s_ready_q;

    // Payload store; contents are irrelevant after reset so it carries none.
    always_ff @(posedge clock_i) begin
        if (load_wr) begin
            buf_q[wcnt_q] <= s_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            addr_q      <= '0;
            parity_q    <= '0;
            wait_q      <= '0;
            s_ready_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_out_q  <= '0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && (pay_len_i != '0) && (dest_addr_i != 2'd3)) begin
                        len_q       <= pay_len_i;
                        addr_q      <= dest_addr_i;
                        parity_q    <= {pay_len_i, dest_addr_i};
                        err_flag_q  <= 1'b0;
                        wcnt_q      <= '0;
                        s_ready_q   <= 1'b1;
                        tx_active_q <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_wr) begin
                        parity_q <= parity_q ^ s_data_i;
                        // Header goes out on the same edge that takes the last byte.
                        if (wcnt_q == last_idx) begin
                            s_ready_q   <= 1'b0;
                            pkt_valid_q <= 1'b1;
                            data_out_q  <= hdr;
                            state_q     <= S_HEADER;
                        end else begin
                            wcnt_q <= LEN_W'(wcnt_q + 1'b1);
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy_i) begin
                        data_out_q <= buf_q[0];
                        rcnt_q     <= '0;
                        state_q    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy_i) begin
                        if (rcnt_q == last_idx) begin
                            pkt_valid_q <= 1'b0;
                            data_out_q  <= parity_q;
                            state_q     <= S_PARITY;
                        end else begin
                            rcnt_q     <= LEN_W'(rcnt_q + 1'b1);
                            data_out_q <= buf_q[LEN_W'(rcnt_q + 1'b1)];
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy_i) begin
                        data_out_q <= '0;
                        wait_q     <= '0;
                        state_q    <= S_ERRW;
                    end
                end
                S_ERRW: begin
                    // Give the router time to raise err for this packet's parity.
                    if (wait_q == WAIT_W'(ERR_WAIT - 1)) begin
                        err_flag_q  <= err_i;
                        done_q      <= 1'b1;
                        tx_active_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        wait_q <= WAIT_W'(wait_q + 1'b1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready_o   = s_ready_q;
    assign pkt_valid_o = pkt_valid_q;
    assign data_out_o  = data_out_q;
    assign tx_active_o = tx_active_q;
    assign done_o      = done_q;
    assign err_flag_o  = err_flag_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Bench for router_pkt_src: fixed cycle vectors, hand sequences for reset and err,
// and random packets checked against a packet-level model of the byte stream.
module tb_router_pkt_src;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       busy;
    logic       err;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       done;
    logic       err_flag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    router_pkt_src dut (
        .clock_i    (clk),
        .resetn_i   (resetn),
        .start_i    (start),
        .dest_addr_i(dest_addr),
        .pay_len_i  (pay_len),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .busy_i     (busy),
        .err_i      (err),
        .pkt_valid_o(pkt_valid),
        .data_out_o (data_out),
        .tx_active_o(tx_active),
        .done_o     (done),
        .err_flag_o (err_flag)
    );

    typedef struct {
        logic        st;
        logic [5:0]  len;
        logic [1:0]  addr;
        logic        sv;
        logic [7:0]  sd;
        logic        bsy;
        logic        er;
        logic [12:0] exp;  // {pkt_valid, data_out, s_ready, tx_active, done, err_flag}
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] obs();
        return {pkt_valid, data_out, s_ready, tx_active, done, err_flag};
    endfunction

    task automatic add(input int st, input int len, input int addr, input int sv,
                       input int sd, input int bsy, input int er, input int pv,
                       input int dout, input int sr, input int tx, input int dn,
                       input int ef);
        vec_t v;
        v.st   = 1'(st);
        v.len  = 6'(len);
        v.addr = 2'(addr);
        v.sv   = 1'(sv);
        v.sd   = 8'(sd);
        v.bsy  = 1'(bsy);
        v.er   = 1'(er);
        v.exp  = {1'(pv), 8'(dout), 1'(sr), 1'(tx), 1'(dn), 1'(ef)};
        tbl.push_back(v);
    endtask

    // One packet: host load with random gaps, router drain with random busy.
    task automatic run_pkt(input logic [5:0] len, input logic [1:0] addr,
                           input int sv_pct, input int busy_pct, input logic err_v);
        logic [7:0] pay[$];
        logic [8:0] exp_s[$];
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b8;
        logic [8:0] prev;
        logic       acc;
        logic       b;
        int         got;
        int         idx;
        int         cyc;

        hdr = {len, addr};
        par = hdr;
        exp_s.push_back({1'b1, hdr});
        for (int i = 0; i < int'(len); i++) begin
            b8 = 8'($urandom);
            pay.push_back(b8);
            par = par ^ b8;
            exp_s.push_back({1'b1, b8});
        end
        exp_s.push_back({1'b0, par});

        start     = 1'b1;
        pay_len   = len;
        dest_addr = addr;
        @(negedge clk);
        start = 1'b0;
        chk("start_acc", 32'(obs()), 32'({1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}));

        got = 0;
        cyc = 0;
        while (got < int'(len) && cyc < 4000) begin
            s_valid = (int'($urandom_range(99)) < sv_pct);
            s_data  = pay[got];
            acc     = s_valid && s_ready;
            @(negedge clk);
            cyc++;
            if (acc) got++;
        end
        s_valid = 1'b0;
        chk("load_count", 32'(got), 32'(len));
        chk("hdr_latency", 32'({pkt_valid, data_out, s_ready}), 32'({1'b1, hdr, 1'b0}));

        idx = 0;
        cyc = 0;
        while (idx < exp_s.size() && cyc < 4000) begin
            b    = (int'($urandom_range(99)) < busy_pct);
            busy = b;
            prev = {pkt_valid, data_out};
            if (!b) begin
                chk("stream", 32'(prev), 32'(exp_s[idx]));
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (b) chk("hold", 32'({pkt_valid, data_out}), 32'(prev));
        end
        busy = 1'b0;
        chk("stream_len", 32'(idx), 32'(exp_s.size()));

        // err is only honoured on the last ERRW edge; drive the opposite before it.
        for (int k = 1; k <= 3; k++) begin
            chk("errw", 32'({done, tx_active, pkt_valid, data_out}),
                32'({1'b0, 1'b1, 1'b0, 8'h00}));
            err = (k == 3) ? err_v : ~err_v;
            @(negedge clk);
        end
        chk("done", 32'({done, tx_active, err_flag}), 32'({1'b1, 1'b0, err_v}));
        err = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        dest_addr = 2'd0;
        pay_len   = 6'd0;
        s_data    = 8'd0;
        s_valid   = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(obs()), 32'd0);
        resetn = 1'b1;

        // len=3 addr=1, bytes 11 22 33, no busy: HDR and parity are both 0D.
        add(1, 3, 1, 0, 'h00, 0, 0,  0, 'h00, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h11, 0, 0,  0, 'h00, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h22, 0, 0,  0, 'h00, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h33, 0, 0,  1, 'h0D, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  1, 'h11, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  1, 'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  1, 'h33, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h0D, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 1, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 0, 0);
        // Same packet, stray start while loading, busy held 4 cycles on 22, err=1.
        add(1, 3, 1, 0, 'h00, 0, 0,  0, 'h00, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h11, 0, 0,  0, 'h00, 1, 1, 0, 0);
        add(1, 5, 0, 1, 'h22, 0, 0,  0, 'h00, 1, 1, 0, 0);
        add(0, 0, 0, 1, 'h33, 0, 0,  1, 'h0D, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  1, 'h11, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  1, 'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 1, 0,  1, 'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 1, 0,  1, 'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 1, 0,  1, 'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 1, 0,  1, 'h22, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  1, 'h33, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h0D, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 1,  0, 'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 1, 0, 0);
        add(0, 0, 0, 0, 'h00, 0, 1,  0, 'h00, 0, 0, 1, 1);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 0, 1);
        // Invalid starts: zero length, then dest 3; err_flag must stay set.
        add(1, 0, 1, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 0, 1);
        add(1, 5, 3, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 0, 1);
        add(0, 0, 0, 0, 'h00, 0, 0,  0, 'h00, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            start     = tbl[i].st;
            pay_len   = tbl[i].len;
            dest_addr = tbl[i].addr;
            s_valid   = tbl[i].sv;
            s_data    = tbl[i].sd;
            busy      = tbl[i].bsy;
            err       = tbl[i].er;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end
        start   = 1'b0;
        s_valid = 1'b0;
        busy    = 1'b0;
        err     = 1'b0;

        // Reset pulse in the middle of the payload.
        start     = 1'b1;
        pay_len   = 6'd4;
        dest_addr = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_pv", 32'({pkt_valid, tx_active}), 32'({1'b1, 1'b1}));
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_reset", 32'(obs()), 32'd0);
        resetn = 1'b1;
        run_pkt(6'd5, 2'd1, 100, 0, 1'b0);

        // err captured, held through idle and a bad start, cleared by a good start.
        run_pkt(6'd2, 2'd2, 100, 0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("err_hold", 32'({err_flag, done, tx_active}), 32'({1'b1, 1'b0, 1'b0}));
        end
        start   = 1'b1;
        pay_len = 6'd0;
        @(negedge clk);
        start = 1'b0;
        chk("err_hold_bad_start", 32'({err_flag, tx_active}), 32'({1'b1, 1'b0}));
        run_pkt(6'd7, 2'd0, 70, 30, 1'b0);

        // Full-length packet with 50% host gaps; run back-to-back on done.
        run_pkt(6'd63, 2'd0, 50, 0, 1'($urandom));

        for (int p = 0; p < 20; p++) begin
            run_pkt(6'($urandom_range(63, 1)), 2'($urandom_range(2)),
                    int'($urandom_range(100, 30)), int'($urandom_range(60)),
                    1'($urandom));
            if ($urandom_range(1) == 1) repeat (int'($urandom_range(3, 1))) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
